// File: rtl/ahblite_dtcm_pkg.sv
// Shared types and encodings for the DTCM AHB-Lite SRAM responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ahblite_dtcm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_DLY,
    S_ERR1,
    S_ERR2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

endpackage

// File: rtl/ahblite_byte_mask.sv
// Byte-lane mask and size/alignment legality for one AHB transfer.
// Latency: combinational.
// Backpressure: none.
module ahblite_byte_mask
  import ahblite_dtcm_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] mask_o,
  output logic       illegal_o
);

  // Decode lane mask; anything wider than a word or misaligned is illegal.
  always_comb begin
    mask_o    = 4'b0000;
    illegal_o = 1'b0;
    case (size_i)
      HSIZE_BYTE: mask_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        mask_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        illegal_o = addr_lo_i[0];
      end
      HSIZE_WORD: begin
        mask_o    = 4'b1111;
        illegal_o = |addr_lo_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahblite_dtcm_sram_responder.sv
// AHB-Lite slave mapping DTCM transfers onto a 1-cycle single-port SRAM.
// Latency: writes zero-wait; reads 1 cycle (+1 after a write, +WAIT_STATES).
// Backpressure: HREADYOUT low during deferred read, read waits and ERROR first cycle.
module ahblite_dtcm_sram_responder
  import ahblite_dtcm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  SRAM_CS,
  output logic [3:0]            SRAM_WE,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [31:0]           SRAM_WDATA,
  input  logic [31:0]           SRAM_RDATA
);

  localparam logic [1:0] WAIT_INIT = 2'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [1:0]            wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            mask_q, mask_d;

  logic                  accept;
  logic                  illegal;
  logic                  hready;
  logic [3:0]            mask_acc;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic                  unused_ok;

  assign accept     = HSEL & HTRANS[1] & HREADY;
  // Upper address bits alias onto the SRAM; burst/prot carry no meaning here.
  assign haddr_word = HADDR[ADDR_WIDTH+1:2];
  assign unused_ok  = ^{HBURST, HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};
  assign HREADYOUT  = hready;

  ahblite_byte_mask u_byte_mask (
    .size_i    (HSIZE),
    .addr_lo_i (HADDR[1:0]),
    .mask_o    (mask_acc),
    .illegal_o (illegal)
  );

  // Data-phase outputs per state, then next address phase decode when ready.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    hready     = 1'b1;
    HRESP      = 1'b0;
    HRDATA     = '0;
    SRAM_CS    = 1'b0;
    SRAM_WE    = 4'b0000;
    SRAM_ADDR  = '0;
    SRAM_WDATA = '0;

    case (state_q)
      S_WR: begin
        SRAM_CS    = 1'b1;
        SRAM_WE    = mask_q;
        SRAM_ADDR  = addr_q;
        SRAM_WDATA = HWDATA;
      end
      S_RD: begin
        hready = (wait_q == 2'd0);
        if (wait_q != 2'd0) wait_d = wait_q - 2'd1;
        else                HRDATA = SRAM_RDATA;
      end
      S_RD_DLY: begin
        SRAM_CS   = 1'b1;
        SRAM_ADDR = addr_q;
        hready    = 1'b0;
        state_d   = S_RD;
        wait_d    = WAIT_INIT;
      end
      S_ERR1: begin
        hready  = 1'b0;
        HRESP   = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase

    if (hready) begin
      state_d = S_IDLE;
      if (accept) begin
        if (illegal) begin
          state_d = S_ERR1;
        end else if (HWRITE) begin
          state_d = S_WR;
          addr_d  = haddr_word;
          mask_d  = mask_acc;
        end else if (state_q == S_WR) begin
          // SRAM port busy with the write data phase: defer the read a cycle.
          state_d = S_RD_DLY;
          addr_d  = haddr_word;
        end else begin
          state_d   = S_RD;
          wait_d    = WAIT_INIT;
          SRAM_CS   = 1'b1;
          SRAM_ADDR = haddr_word;
        end
      end
    end

    // A write in flight when reset hits is dropped; no SRAM access under reset.
    if (HRESET) begin
      SRAM_CS    = 1'b0;
      SRAM_WE    = 4'b0000;
      SRAM_ADDR  = '0;
      SRAM_WDATA = '0;
    end
  end

  // State, wait counter and latched address/mask registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

endmodule
